// File: rtl/fisr_pkg.sv
// Shared constants, state encoding and result-class helpers for the
// fast inverse-square-root sequencer.
package fisr_pkg;

    localparam logic [31:0] MAGIC      = 32'h5F3759DF;
    localparam logic [31:0] ONE_P_FIVE = 32'h3FC00000;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] PINF       = 32'h7F800000;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLASSIFY = 3'd1;
    localparam logic [2:0] S_SEED     = 3'd2;
    localparam logic [2:0] S_MUL_YY   = 3'd3;
    localparam logic [2:0] S_MUL_XT   = 3'd4;
    localparam logic [2:0] S_SUB      = 3'd5;
    localparam logic [2:0] S_MUL_YT   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    typedef enum logic [1:0] {
        FLAG_NORMAL  = 2'd0,
        FLAG_ZERO    = 2'd1,
        FLAG_NEG_NAN = 2'd2,
        FLAG_PINF    = 2'd3
    } fisr_flag_e;

    // Zero/denormal wins over sign, so -0 is treated as zero rather than negative.
    function automatic fisr_flag_e fisr_classify(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'h00)
            return FLAG_ZERO;
        if (e == 8'hFF && x[22:0] != 23'd0)
            return FLAG_NEG_NAN;
        if (x[31])
            return FLAG_NEG_NAN;
        if (e == 8'hFF)
            return FLAG_PINF;
        return FLAG_NORMAL;
    endfunction

    function automatic logic [31:0] fisr_special_value(input fisr_flag_e flag);
        case (flag)
            FLAG_ZERO:    return PINF;
            FLAG_NEG_NAN: return QNAN;
            default:      return 32'h0000_0000;
        endcase
    endfunction

    // Halving by exponent decrement; the smallest normal would become a
    // denormal, which the downstream units do not handle, so it flushes to 0.
    function automatic logic [31:0] fisr_half(input logic [31:0] x);
        if (x[30:23] == 8'h01)
            return 32'h0000_0000;
        return {x[31], x[30:23] - 8'h01, x[22:0]};
    endfunction

endpackage

// File: rtl/fisr_op_timer.sv
// Loadable down-counter that pulses done in the cycle its count steps to zero,
// marking the capture cycle of an outstanding multiply or subtract.
module fisr_op_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    assign done = (cnt_q == W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fisr_sequencer.sv
// Control FSM for the fast inverse-square-root datapath: seeds y0 with the
// bit trick and time-shares one multiplier and one subtractor for Newton steps.
//
// state    | meaning
// IDLE     | ready for x
// CLASSIFY | sort x into normal / zero / negative-NaN / +inf
// SEED     | y0 = MAGIC - (x>>1), x_half = x/2
// MUL_YY   | t = y*y
// MUL_XT   | t = x_half*t
// SUB      | t = 1.5 - t
// MUL_YT   | y = y*t, count iteration
// DONE     | hold result until out_ready
module fisr_sequencer
    import fisr_pkg::*;
#(
    parameter int N_ITER  = 1,
    parameter int MUL_LAT = 2,
    parameter int SUB_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        mul_ce,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p,
    output logic        sub_ce,
    output logic [31:0] sub_a,
    output logic [31:0] sub_b,
    input  logic [31:0] sub_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flag,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > SUB_LAT) ? MUL_LAT : SUB_LAT;
    localparam int TW      = $clog2(MAX_LAT + 1);
    localparam logic [TW-1:0] MUL_LOAD  = TW'(MUL_LAT);
    localparam logic [TW-1:0] SUB_LOAD  = TW'(SUB_LAT);
    localparam logic [1:0]    ITER_LAST = 2'(N_ITER);

    logic [2:0]  state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] xh_q, xh_d;
    logic [31:0] y_q, y_d;
    logic [31:0] t_q, t_d;
    logic [31:0] out_data_q, out_data_d;
    fisr_flag_e  out_flag_q, out_flag_d;
    logic [1:0]  iter_q, iter_d;
    logic        wait_q, wait_d;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;
    logic [1:0]    iter_inc;
    fisr_flag_e    x_class;

    assign iter_inc = iter_q + 2'd1;
    assign x_class  = fisr_classify(x_q);

    fisr_op_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        xh_d       = xh_q;
        y_d        = y_q;
        t_d        = t_q;
        out_data_d = out_data_q;
        out_flag_d = out_flag_q;
        iter_d     = iter_q;
        wait_d     = wait_q;
        timer_load = 1'b0;
        timer_val  = '0;
        mul_ce     = 1'b0;
        mul_a      = 32'h0;
        mul_b      = 32'h0;
        sub_ce     = 1'b0;
        sub_a      = 32'h0;
        sub_b      = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d        = in_data;
                    out_data_d = 32'h0;
                    out_flag_d = FLAG_NORMAL;
                    state_d    = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (x_class != FLAG_NORMAL) begin
                    out_data_d = fisr_special_value(x_class);
                    out_flag_d = x_class;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                y_d     = MAGIC - {1'b0, x_q[31:1]};
                xh_d    = fisr_half(x_q);
                iter_d  = 2'd0;
                wait_d  = 1'b0;
                state_d = S_MUL_YY;
            end
            S_MUL_YY, S_MUL_XT, S_MUL_YT: begin
                mul_a = (state_q == S_MUL_XT) ? xh_q : y_q;
                mul_b = (state_q == S_MUL_YY) ? y_q  : t_q;
                if (!wait_q) begin
                    mul_ce     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = MUL_LOAD;
                    wait_d     = 1'b1;
                end else if (timer_done) begin
                    wait_d = 1'b0;
                    if (state_q == S_MUL_YY) begin
                        t_d     = mul_p;
                        state_d = S_MUL_XT;
                    end else if (state_q == S_MUL_XT) begin
                        t_d     = mul_p;
                        state_d = S_SUB;
                    end else begin
                        y_d    = mul_p;
                        iter_d = iter_inc;
                        if (iter_inc == ITER_LAST) begin
                            out_data_d = mul_p;
                            out_flag_d = FLAG_NORMAL;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_MUL_YY;
                        end
                    end
                end
            end
            S_SUB: begin
                sub_a = ONE_P_FIVE;
                sub_b = t_q;
                if (!wait_q) begin
                    sub_ce     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = SUB_LOAD;
                    wait_d     = 1'b1;
                end else if (timer_done) begin
                    wait_d  = 1'b0;
                    t_d     = sub_r;
                    state_d = S_MUL_YT;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_flag  = out_flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= 32'h0;
            xh_q       <= 32'h0;
            y_q        <= 32'h0;
            t_q        <= 32'h0;
            out_data_q <= 32'h0;
            out_flag_q <= FLAG_NORMAL;
            iter_q     <= 2'd0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            xh_q       <= xh_d;
            y_q        <= y_d;
            t_q        <= t_d;
            out_data_q <= out_data_d;
            out_flag_q <= out_flag_d;
            iter_q     <= iter_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_fisr_sequencer.sv
// Bench for fisr_sequencer: two instances (N_ITER=1 and N_ITER=2) share one
// clock; each gets its own behavioural multiplier/subtractor pipeline.
module tb_fisr_sequencer;

    localparam int MUL_LAT = 2;
    localparam int SUB_LAT = 2;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] d;
        logic [1:0]  f;
        int          ppm;   // -1 means exact bit match
    } vec_t;

    typedef struct packed {
        int          cyc;
        logic        is_sub;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_data  [2];
    logic        mul_ce   [2];
    logic [31:0] mul_a    [2];
    logic [31:0] mul_b    [2];
    logic [31:0] mul_p    [2];
    logic        sub_ce   [2];
    logic [31:0] sub_a    [2];
    logic [31:0] sub_b    [2];
    logic [31:0] sub_r    [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [31:0] out_data [2];
    logic [1:0]  out_flag [2];
    logic        busy     [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mul_n [2];
    int sub_n [2];
    int overlap_n = 0;
    int unstable_n = 0;
    int hold_n [2];
    logic [127:0] held [2];
    vec_t sb_q [$];
    ev_t  tr_q [$];

    logic [31:0] mp [2][MUL_LAT];
    logic        mv [2][MUL_LAT];
    logic [31:0] sp [2][SUB_LAT];
    logic        sv [2][SUB_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        fisr_sequencer #(
            .N_ITER  (k + 1),
            .MUL_LAT (MUL_LAT),
            .SUB_LAT (SUB_LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_data   (in_data[k]),
            .mul_ce    (mul_ce[k]),
            .mul_a     (mul_a[k]),
            .mul_b     (mul_b[k]),
            .mul_p     (mul_p[k]),
            .sub_ce    (sub_ce[k]),
            .sub_a     (sub_a[k]),
            .sub_b     (sub_b[k]),
            .sub_r     (sub_r[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k]),
            .out_flag  (out_flag[k]),
            .busy      (busy[k])
        );
    end

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] dbits;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        dbits = $realtobits(r);
        e = dbits[62:52] - 11'd896;
        return {dbits[63], e[7:0], dbits[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) - f2r(b));
    endfunction

    // Results appear LAT cycles after the issue cycle; garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mp[k][0] <= fmul(mul_a[k], mul_b[k]);
            mv[k][0] <= mul_ce[k];
            for (int i = 1; i < MUL_LAT; i++) begin
                mp[k][i] <= mp[k][i-1];
                mv[k][i] <= mv[k][i-1];
            end
            sp[k][0] <= fsub(sub_a[k], sub_b[k]);
            sv[k][0] <= sub_ce[k];
            for (int i = 1; i < SUB_LAT; i++) begin
                sp[k][i] <= sp[k][i-1];
                sv[k][i] <= sv[k][i-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mul_p[k] = (mv[k][MUL_LAT-1] === 1'b1) ? mp[k][MUL_LAT-1] : 32'hDEADBEEF;
            sub_r[k] = (sv[k][SUB_LAT-1] === 1'b1) ? sp[k][SUB_LAT-1] : 32'hBADC0FFE;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mul_ce[k] && sub_ce[k]) overlap_n++;
            if (mul_ce[k]) mul_n[k]++;
            if (sub_ce[k]) sub_n[k]++;
            if (!rst) begin
                hold_n[k] = 0;
            end else if (hold_n[k] > 0) begin
                if ({mul_a[k], mul_b[k], sub_a[k], sub_b[k]} != held[k]) unstable_n++;
                hold_n[k]--;
            end
            if (mul_ce[k] || sub_ce[k]) begin
                held[k]   = {mul_a[k], mul_b[k], sub_a[k], sub_b[k]};
                hold_n[k] = mul_ce[k] ? MUL_LAT : SUB_LAT;
                if (k == 0)
                    tr_q.push_back('{cyc, sub_ce[k], sub_ce[k] ? sub_a[k] : mul_a[k],
                                     sub_ce[k] ? sub_b[k] : mul_b[k]});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input logic [31:0] exp,
                            input int ppm);
        real ra, re, err;
        checks++;
        ra  = f2r(act);
        re  = f2r(exp);
        err = (ra - re) / re;
        if (err < 0.0) err = -err;
        if (err * 1.0e6 > real'(ppm)) begin
            failures++;
            $display("FAIL %s: got %h (%g) expected %h (%g) within %0d ppm",
                     name, act, ra, exp, re, ppm);
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic run_txn(input int k, input vec_t v, input int hold,
                           input logic [31:0] next_x, output int acc);
        int   n;
        int   budget;
        vec_t e;
        logic [31:0] d0;
        logic [1:0]  f0;
        n = k + 1;
        sb_q.push_back(v);
        in_data[k]  = v.x;
        in_valid[k] = 1'b1;
        budget = 0;
        while (!in_ready[k] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("accept_ready", 32'(in_ready[k]), 32'd1);
        mul_n[k] = 0;
        sub_n[k] = 0;
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
        acc = cyc;
        @(negedge clk);
        while (!out_valid[k] && (cyc - acc) < 100) @(negedge clk);
        e = sb_q.pop_front();
        chk("latency", cyc - acc,
            (e.f == 2'd0) ? 2 + n * (3 * (1 + MUL_LAT) + (1 + SUB_LAT)) : 1);
        if (e.ppm < 0) chk("out_data", out_data[k], e.d);
        else           chk_near("out_data", out_data[k], e.d, e.ppm);
        chk("out_flag", 32'(out_flag[k]), 32'(e.f));
        // Three multiplies and one subtract per Newton iteration.
        chk("mul_pulses", mul_n[k], (e.f == 2'd0) ? 3 * n : 0);
        chk("sub_pulses", sub_n[k], (e.f == 2'd0) ? n : 0);
        if (hold > 0) begin
            d0 = out_data[k];
            f0 = out_flag[k];
            in_data[k]  = next_x;
            in_valid[k] = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_data", out_data[k], d0);
                chk("hold_flag", 32'(out_flag[k]), 32'(f0));
                chk("hold_valid", 32'(out_valid[k]), 32'd1);
                chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
                chk("hold_busy", 32'(busy[k]), 32'd1);
            end
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1 out_ready[k] = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready[k]), 32'd1);
        chk("post_out_valid", 32'(out_valid[k]), 32'd0);
        chk("post_busy", 32'(busy[k]), 32'd0);
    endtask

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready[k]), 32'd1);
        chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid[k]), 32'd0);
        chk({tag, "_mul_ce"}, 32'(mul_ce[k]), 32'd0);
        chk({tag, "_sub_ce"}, 32'(sub_ce[k]), 32'd0);
        chk({tag, "_mul_a"}, mul_a[k], 32'h0);
        chk({tag, "_mul_b"}, mul_b[k], 32'h0);
        chk({tag, "_sub_b"}, sub_b[k], 32'h0);
        chk({tag, "_out_data"}, out_data[k], 32'h0);
        chk({tag, "_out_flag"}, 32'(out_flag[k]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        vec_t v4;
        int   acc;
        logic [31:0] y0, t1, t2, t3;
        ev_t  ex [4];

        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = 32'h0;
            out_ready[k] = 1'b0;
            mul_n[k]     = 0;
            sub_n[k]     = 0;
            hold_n[k]    = 0;
        end

        tbl[0]  = '{32'h40800000, 32'h3F000000, 2'd0, 2000};
        tbl[1]  = '{32'h00000000, 32'h7F800000, 2'd1, -1};
        tbl[2]  = '{32'hC0000000, 32'h7FC00000, 2'd2, -1};
        tbl[3]  = '{32'h7F800000, 32'h00000000, 2'd3, -1};
        tbl[4]  = '{32'h7FC00001, 32'h7FC00000, 2'd2, -1};
        tbl[5]  = '{32'h80000000, 32'h7F800000, 2'd1, -1};
        tbl[6]  = '{32'h00000001, 32'h7F800000, 2'd1, -1};
        tbl[7]  = '{32'hFF800000, 32'h7FC00000, 2'd2, -1};
        tbl[8]  = '{32'h3F800000, 32'h3F800000, 2'd0, 2000};
        tbl[9]  = '{32'h41100000, 32'h3EAAAAAB, 2'd0, 2000};
        // Smallest normal: x_half flushes to zero, so the step is just 1.5*y0.
        tbl[10] = '{32'h00800000, 32'h5F398367, 2'd0, 10};
        v4 = tbl[0];

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk_reset_outputs(k, "reset");
        #2 rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_txn(0, tbl[i], 0, 32'h0, acc);

        // Seed check and operand trace for x = 1.0.
        y0 = 32'h3F7759DF;
        t1 = fmul(y0, y0);
        t2 = fmul(32'h3F000000, t1);
        t3 = fsub(32'h3FC00000, t2);
        tr_q.delete();
        run_txn(0, tbl[8], 0, 32'h0, acc);
        ex[0] = '{acc + 2, 1'b0, y0, y0};
        ex[1] = '{acc + 2 + (1 + MUL_LAT), 1'b0, 32'h3F000000, t1};
        ex[2] = '{acc + 2 + 2 * (1 + MUL_LAT), 1'b1, 32'h3FC00000, t2};
        ex[3] = '{acc + 2 + 2 * (1 + MUL_LAT) + (1 + SUB_LAT), 1'b0, y0, t3};
        chk("trace_count", tr_q.size(), 4);
        for (int i = 0; i < 4 && i < tr_q.size(); i++) begin
            chk($sformatf("trace%0d_cycle", i), tr_q[i].cyc, ex[i].cyc);
            chk($sformatf("trace%0d_is_sub", i), 32'(tr_q[i].is_sub), 32'(ex[i].is_sub));
            chk($sformatf("trace%0d_a", i), tr_q[i].a, ex[i].a);
            chk($sformatf("trace%0d_b", i), tr_q[i].b, ex[i].b);
        end

        // Backpressure with the next x already waiting, then that x.
        run_txn(0, v4, 5, v4.x, acc);
        run_txn(0, v4, 0, 32'h0, acc);

        // Reset during the MUL_XT wait cycle.
        in_data[0]  = v4.x;
        in_valid[0] = 1'b1;
        mul_n[0]    = 0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("rst_mid_mul_pulses", mul_n[0], 2);
        chk("rst_mid_busy_before", 32'(busy[0]), 32'd1);
        #1 rst = 1'b0;
        #1 chk_reset_outputs(0, "rst_mid");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        run_txn(0, v4, 0, 32'h0, acc);

        // Two-iteration instance.
        run_txn(1, '{32'h40800000, 32'h3F000000, 2'd0, 10}, 0, 32'h0, acc);
        run_txn(1, '{32'h3F800000, 32'h3F800000, 2'd0, 10}, 0, 32'h0, acc);
        run_txn(1, tbl[3], 0, 32'h0, acc);

        chk("no_mul_sub_overlap", overlap_n, 0);
        chk("operands_stable", unstable_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
